// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: instruction-memory address/data, branch redirect and the
// valid/ready handshake toward decode. master = fetch unit, slave = its environment.
interface fetch_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] pc_address;
  logic [DATA_WIDTH-1:0] instruction;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_target;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [DATA_WIDTH-1:0] out_pc;
  logic                  fetch_fault;

  modport master (
    output pc_address, out_valid, out_instr, out_pc, fetch_fault,
    input  instruction, redirect_valid, redirect_target, out_ready
  );

  modport slave (
    input  pc_address, out_valid, out_instr, out_pc, fetch_fault,
    output instruction, redirect_valid, redirect_target, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, 2-entry {instr, pc} queue toward decode,
// branch redirect with flush, and sticky out-of-range fetch fault.
module fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] pc, pc_n;
  logic                  fault, fault_n;
  logic [DATA_WIDTH-1:0] fifo_instr [2];
  logic [DATA_WIDTH-1:0] fifo_pc    [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;
  logic                  push, pop, flush;
  logic                  out_of_range;
  logic                  unused_target_bits;

  assign out_of_range       = |pc[DATA_WIDTH-1:ADDR_WIDTH+2];
  assign pop                = (count != 2'd0) && bus.out_ready;
  // With two slots, the write slot is rd_ptr + count (mod 2); when full and
  // popping this lands on the slot being vacated this cycle.
  assign wr_ptr             = rd_ptr ^ count[0];
  assign unused_target_bits = ^bus.redirect_target[1:0];

  always_comb begin
    state_n = state;
    pc_n    = pc;
    fault_n = fault;
    push    = 1'b0;
    flush   = 1'b0;
    if (state != BOOT && bus.redirect_valid) begin
      flush   = 1'b1;
      pc_n    = {bus.redirect_target[DATA_WIDTH-1:2], 2'b00};
      fault_n = 1'b0;
      state_n = RUN;
    end else begin
      unique case (state)
        BOOT: state_n = RUN;
        RUN: begin
          if (out_of_range) begin
            fault_n = 1'b1;
            state_n = FAULT;
          end else if (count != 2'd2 || pop) begin
            push = 1'b1;
            pc_n = pc + DATA_WIDTH'(4);
          end
        end
        FAULT: ;
        default: state_n = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= BOOT;
      pc     <= RESET_PC;
      fault  <= 1'b0;
      count  <= '0;
      rd_ptr <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else begin
      state <= state_n;
      pc    <= pc_n;
      fault <= fault_n;
      if (flush) begin
        count  <= '0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) begin
          fifo_instr[wr_ptr] <= bus.instruction;
          fifo_pc[wr_ptr]    <= pc;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        unique case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  assign bus.pc_address  = pc;
  assign bus.out_valid   = (count != 2'd0);
  assign bus.out_instr   = fifo_instr[rd_ptr];
  assign bus.out_pc      = fifo_pc[rd_ptr];
  assign bus.fetch_fault = fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: queue-based reference model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC    = 32'h0000_0000;
  localparam logic [31:0] MEM_BYTES = 32'h0000_0400;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] imem [256];

  fetch_unit_if #(.DATA_WIDTH(32)) bus ();

  fetch_unit #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(8),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.instruction = (bus.pc_address < MEM_BYTES) ? imem[bus.pc_address[9:2]] : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of delivered-to-be entries plus the fetch address.
  entry_t      mq[$];
  logic [31:0] m_pc;
  bit          m_fault;
  bit          m_boot;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_pc    = RST_PC;
      m_fault = 1'b0;
      m_boot  = 1'b1;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (bus.redirect_valid) begin
      mq.delete();
      m_pc    = bus.redirect_target & ~32'h3;
      m_fault = 1'b0;
    end else begin
      if (mq.size() != 0 && bus.out_ready) void'(mq.pop_front());
      if (!m_fault) begin
        if (m_pc >= MEM_BYTES) begin
          m_fault = 1'b1;
        end else if (mq.size() < 2) begin
          mq.push_back('{instr: imem[m_pc[9:2]], pc: m_pc});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("model_out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("model_out_pc", bus.out_pc, mq[0].pc);
      check("model_out_instr", bus.out_instr, mq[0].instr);
    end
    check("model_pc_address", bus.pc_address, m_pc);
    check("model_fetch_fault", 32'(bus.fetch_fault), 32'(m_fault));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA500_0000;
    imem[0] = 32'h0050_0093;
    imem[1] = 32'h00A0_0113;
    imem[2] = 32'h0020_81B3;

    rst_n               = 1'b1;
    bus.out_ready       = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_pc", bus.out_pc, 32'd0);
    check("rst_out_instr", bus.out_instr, 32'd0);
    check("rst_fault", 32'(bus.fetch_fault), 32'd0);
    check("rst_pc", bus.pc_address, RST_PC);

    // streaming after reset
    cyc(2); rst_n = 1'b1;
    cyc(1);
    check("boot_valid", 32'(bus.out_valid), 32'd0);
    check("boot_pc", bus.pc_address, 32'h0);
    cyc(1);
    check("s0_valid", 32'(bus.out_valid), 32'd1);
    check("s0_pc", bus.out_pc, 32'h0);
    check("s0_instr", bus.out_instr, 32'h0050_0093);
    cyc(1);
    check("s1_valid", 32'(bus.out_valid), 32'd1);
    check("s1_pc", bus.out_pc, 32'h4);
    check("s1_instr", bus.out_instr, 32'h00A0_0113);
    cyc(1);
    check("s2_valid", 32'(bus.out_valid), 32'd1);
    check("s2_pc", bus.out_pc, 32'h8);
    check("s2_instr", bus.out_instr, 32'h0020_81B3);

    // backpressure from reset
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    cyc(1); rst_n = 1'b1;
    cyc(5);
    check("stall_head", bus.out_pc, 32'h0);
    check("stall_pc", bus.pc_address, 32'h8);
    bus.out_ready = 1'b1;
    cyc(1); check("drain_4", bus.out_pc, 32'h4);
    cyc(1); check("drain_8", bus.out_pc, 32'h8);
    cyc(1); check("drain_c", bus.out_pc, 32'hC);

    // redirect with full FIFO, misaligned target
    bus.out_ready = 1'b0;
    cyc(3);
    check("full_valid", 32'(bus.out_valid), 32'd1);
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h43;
    cyc(1); bus.redirect_valid = 1'b0;
    check("redir_flush", 32'(bus.out_valid), 32'd0);
    check("redir_pc", bus.pc_address, 32'h40);
    cyc(1);
    check("redir_head", bus.out_pc, 32'h40);

    // run off the end of memory into FAULT, then recover
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h3FC;
    cyc(1); bus.redirect_valid = 1'b0;
    check("edge_pc", bus.pc_address, 32'h3FC);
    cyc(1);
    check("edge_head", bus.out_pc, 32'h3FC);
    check("edge_pc2", bus.pc_address, 32'h400);
    check("edge_nofault", 32'(bus.fetch_fault), 32'd0);
    cyc(1);
    check("fault_set", 32'(bus.fetch_fault), 32'd1);
    check("fault_empty", 32'(bus.out_valid), 32'd0);
    cyc(2);
    check("fault_hold_pc", bus.pc_address, 32'h400);
    check("fault_sticky", 32'(bus.fetch_fault), 32'd1);
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h0;
    cyc(1); bus.redirect_valid = 1'b0;
    check("fault_clear", 32'(bus.fetch_fault), 32'd0);
    cyc(1);
    check("resume_head", bus.out_pc, 32'h0);

    // top-of-address-space target faults without pushing
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'hFFFF_FFFE;
    cyc(1); bus.redirect_valid = 1'b0;
    check("top_pc", bus.pc_address, 32'hFFFF_FFFC);
    cyc(1);
    check("top_fault", 32'(bus.fetch_fault), 32'd1);
    check("top_nopush", 32'(bus.out_valid), 32'd0);

    // fault while stalled with full FIFO, then async reset mid-cycle
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h3F8;
    cyc(1); bus.redirect_valid = 1'b0;
    cyc(3);
    check("sf_fault", 32'(bus.fetch_fault), 32'd1);
    check("sf_head", bus.out_pc, 32'h3F8);
    @(negedge clk); #3 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_fault", 32'(bus.fetch_fault), 32'd0);
    check("arst_pc", bus.pc_address, RST_PC);
    check("arst_out_pc", bus.out_pc, 32'd0);
    cyc(1); rst_n = 1'b1; bus.out_ready = 1'b1;
    cyc(2);
    check("arst_resume", bus.out_pc, 32'h0);

    // redirect coincident with a pop on a full FIFO
    bus.out_ready = 1'b0;
    cyc(3);
    check("rp_full", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h80;
    cyc(1); bus.redirect_valid = 1'b0;
    check("rp_empty", 32'(bus.out_valid), 32'd0);
    check("rp_pc", bus.pc_address, 32'h80);
    cyc(1);
    check("rp_head", bus.out_pc, 32'h80);
    check("rp_instr", bus.out_instr, (32'd32 * 32'h0101_0101) ^ 32'hA500_0000);

    // redirect during BOOT is ignored
    rst_n = 1'b0;
    cyc(1); rst_n = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h100;
    cyc(1); bus.redirect_valid = 1'b0;
    check("boot_ignore_pc", bus.pc_address, RST_PC);
    cyc(1);
    check("boot_ignore_head", bus.out_pc, RST_PC);
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
